// File: rtl/score_counter.sv
// score_counter: four-digit BCD score keeper for the Pacman game.
// Pellet, power-pellet and ghost events are queued in small saturating
// pending counters and drained one at a time through a digit-serial BCD
// adder (one digit per cycle). The committed score saturates at 9999 and
// drives the digit glyph ROM addresses directly.
//
// Ports:
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   clear                        synchronous score clear (new game)
//   pellet_eaten/power_eaten/ghost_eaten  one-cycle event pulses
//   row[3:0]                     glyph row currently being drawn
//   score_thous..score_ones[3:0] committed BCD digits
//   addr_thous..addr_ones[7:0]   glyph ROM addresses {digit, row}
//   busy                         add in progress or event pending
//   saturated                    score has clamped at 9999
module score_counter #(
  parameter logic [15:0] PTS_PELLET = 16'h0010,
  parameter logic [15:0] PTS_POWER  = 16'h0050,
  parameter logic [15:0] PTS_GHOST  = 16'h0200
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       clear,
  input  logic       pellet_eaten,
  input  logic       power_eaten,
  input  logic       ghost_eaten,
  input  logic [3:0] row,
  output logic [3:0] score_thous,
  output logic [3:0] score_hunds,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [7:0] addr_thous,
  output logic [7:0] addr_hunds,
  output logic [7:0] addr_tens,
  output logic [7:0] addr_ones,
  output logic       busy,
  output logic       saturated
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_idx, w_idx_nx;
  logic        r_carry, w_carry_nx;
  logic [15:0] r_work, w_work_nx;
  logic [15:0] r_addend, w_addend_nx;
  logic [15:0] r_score, w_score_nx;
  logic        r_sat, w_sat_nx;
  logic [1:0]  r_pend_pellet, r_pend_power, r_pend_ghost;
  logic [1:0]  w_pend_pellet_nx, w_pend_power_nx, w_pend_ghost_nx;
  logic        w_dec_pellet, w_dec_power, w_dec_ghost;
  logic        w_any_pend;
  logic [4:0]  w_sum;

  // Saturating 0..3 counter; simultaneous increment and decrement cancel.
  function automatic logic [1:0] f_pend(input logic [1:0] cnt,
                                        input logic inc, input logic dec);
    if (inc && !dec) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    if (dec && !inc) return cnt - 2'd1;
    return cnt;
  endfunction

  assign w_any_pend = (r_pend_pellet != 2'd0) || (r_pend_power != 2'd0) ||
                      (r_pend_ghost != 2'd0);

  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_carry_nx   = r_carry;
    w_work_nx    = r_work;
    w_addend_nx  = r_addend;
    w_score_nx   = r_score;
    w_sat_nx     = r_sat;
    w_dec_pellet = 1'b0;
    w_dec_power  = 1'b0;
    w_dec_ghost  = 1'b0;
    w_sum        = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_pend) begin
          w_state_nx = S_ADD;
          w_idx_nx   = '0;
          w_carry_nx = 1'b0;
          w_work_nx  = r_score;
          // Priority: ghost > power > pellet.
          if (r_pend_ghost != 2'd0) begin
            w_dec_ghost = 1'b1;
            w_addend_nx = PTS_GHOST;
          end else if (r_pend_power != 2'd0) begin
            w_dec_power = 1'b1;
            w_addend_nx = PTS_POWER;
          end else begin
            w_dec_pellet = 1'b1;
            w_addend_nx  = PTS_PELLET;
          end
        end
      end
      S_ADD: begin
        w_sum = {1'b0, r_work[{r_idx, 2'b00} +: 4]} +
                {1'b0, r_addend[{r_idx, 2'b00} +: 4]} + {4'd0, r_carry};
        if (w_sum > 5'd9) begin
          w_work_nx[{r_idx, 2'b00} +: 4] = 4'(w_sum - 5'd10);
          w_carry_nx = 1'b1;
        end else begin
          w_work_nx[{r_idx, 2'b00} +: 4] = w_sum[3:0];
          w_carry_nx = 1'b0;
        end
        if (r_idx == 2'd3) w_state_nx = S_COMMIT;
        else               w_idx_nx   = r_idx + 2'd1;
      end
      S_COMMIT: begin
        if (r_carry || r_sat) begin
          w_score_nx = 16'h9999;
          w_sat_nx   = 1'b1;
        end else begin
          w_score_nx = r_work;
        end
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase

    w_pend_pellet_nx = f_pend(r_pend_pellet, pellet_eaten, w_dec_pellet);
    w_pend_power_nx  = f_pend(r_pend_power,  power_eaten,  w_dec_power);
    w_pend_ghost_nx  = f_pend(r_pend_ghost,  ghost_eaten,  w_dec_ghost);

    // clear overrides everything, including same-cycle event pulses.
    if (clear) begin
      w_state_nx       = S_IDLE;
      w_idx_nx         = '0;
      w_carry_nx       = 1'b0;
      w_work_nx        = '0;
      w_addend_nx      = '0;
      w_score_nx       = '0;
      w_sat_nx         = 1'b0;
      w_pend_pellet_nx = '0;
      w_pend_power_nx  = '0;
      w_pend_ghost_nx  = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_carry       <= 1'b0;
      r_work        <= '0;
      r_addend      <= '0;
      r_score       <= '0;
      r_sat         <= 1'b0;
      r_pend_pellet <= '0;
      r_pend_power  <= '0;
      r_pend_ghost  <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_idx         <= w_idx_nx;
      r_carry       <= w_carry_nx;
      r_work        <= w_work_nx;
      r_addend      <= w_addend_nx;
      r_score       <= w_score_nx;
      r_sat         <= w_sat_nx;
      r_pend_pellet <= w_pend_pellet_nx;
      r_pend_power  <= w_pend_power_nx;
      r_pend_ghost  <= w_pend_ghost_nx;
    end
  end

  assign score_thous = r_score[15:12];
  assign score_hunds = r_score[11:8];
  assign score_tens  = r_score[7:4];
  assign score_ones  = r_score[3:0];

  assign addr_thous = {r_score[15:12], row};
  assign addr_hunds = {r_score[11:8],  row};
  assign addr_tens  = {r_score[7:4],   row};
  assign addr_ones  = {r_score[3:0],   row};

  assign busy      = (r_state != S_IDLE) || w_any_pend;
  assign saturated = r_sat;

endmodule

// File: tb/tb_score_counter.sv
module tb_score_counter;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       pellet_eaten = 1'b0;
  logic       power_eaten = 1'b0;
  logic       ghost_eaten = 1'b0;
  logic [3:0] row = 4'd9;
  logic [3:0] score_thous, score_hunds, score_tens, score_ones;
  logic [7:0] addr_thous, addr_hunds, addr_tens, addr_ones;
  logic       busy, saturated;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 Clk = ~Clk;

  score_counter #(
    .PTS_PELLET(16'h0010),
    .PTS_POWER (16'h0050),
    .PTS_GHOST (16'h0200)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .clear(clear),
    .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
    .ghost_eaten(ghost_eaten), .row(row),
    .score_thous(score_thous), .score_hunds(score_hunds),
    .score_tens(score_tens), .score_ones(score_ones),
    .addr_thous(addr_thous), .addr_hunds(addr_hunds),
    .addr_tens(addr_tens), .addr_ones(addr_ones),
    .busy(busy), .saturated(saturated)
  );

  logic [15:0] score;
  logic [31:0] addrs;
  assign score = {score_thous, score_hunds, score_tens, score_ones};
  assign addrs = {addr_thous, addr_hunds, addr_tens, addr_ones};

  typedef struct {
    logic        clr, pel, pow, gho;
    logic [3:0]  rw;
    logic [15:0] exp_score;
    logic        exp_busy;
    logic        exp_sat;
  } rec_t;

  rec_t tbl[$];

  function automatic rec_t mk(input logic c, pe, po, gh, input logic [3:0] r,
                              input logic [15:0] s, input logic b, sat);
    rec_t x;
    x.clr = c; x.pel = pe; x.pow = po; x.gho = gh; x.rw = r;
    x.exp_score = s; x.exp_busy = b; x.exp_sat = sat;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input int unsigned lim);
    int unsigned n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Pulse one source (0 pellet, 1 power, 2 ghost) and let it drain.
  task automatic fire(input int unsigned src);
    pellet_eaten = (src == 0);
    power_eaten  = (src == 1);
    ghost_eaten  = (src == 2);
    tick();
    pellet_eaten = 1'b0; power_eaten = 1'b0; ghost_eaten = 1'b0;
    wait_idle(20);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Expected outputs from a decimal score value and the current row.
  task automatic chk_model(input string nm, input int dec, input logic sat);
    logic [15:0] b;
    b = to_bcd(dec);
    chk({nm, "_score"}, {16'd0, score}, {16'd0, b});
    chk({nm, "_sat"}, {31'd0, saturated}, {31'd0, sat});
    chk({nm, "_addr"}, addrs,
        {8'((dec / 1000 % 10) * 16 + int'(row)), 8'((dec / 100 % 10) * 16 + int'(row)),
         8'((dec / 10 % 10) * 16 + int'(row)),   8'((dec % 10) * 16 + int'(row))});
  endtask

  initial begin
    int model;
    logic msat;
    int unsigned bits;

    // Reset state, row passes straight through to all addresses.
    #12;
    chk("rst_score", {16'd0, score}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sat", {31'd0, saturated}, 32'd0);
    chk("rst_addr", addrs, 32'h09090909);
    Reset_n = 1'b1;
    tick();

    // Single pellet: busy for 6 cycles, score visible after E6.
    tbl.push_back(mk(1, 0, 0, 0, 4'd3, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'd3, 16'h0000, 1, 0));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 0, 0, 0, 4'd3, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3, 16'h0010, 0, 0));
    // clear with a same-cycle ghost pulse: pulse discarded.
    tbl.push_back(mk(1, 0, 0, 1, 4'd7, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd7, 16'h0000, 0, 0));
    // All three at once: 200, 50, 10 with one IDLE cycle between adds.
    tbl.push_back(mk(0, 1, 1, 1, 4'd1, 16'h0000, 1, 0));
    for (int i = 1; i <= 18; i++)
      tbl.push_back(mk(0, 0, 0, 0, 4'(i % 16),
                       (i < 6) ? 16'h0000 : (i < 12) ? 16'h0200 :
                       (i < 18) ? 16'h0250 : 16'h0260,
                       (i < 18) ? 1'b1 : 1'b0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  16'h0260, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd15, 16'h0260, 0, 0));

    foreach (tbl[i]) begin
      clear = tbl[i].clr; pellet_eaten = tbl[i].pel;
      power_eaten = tbl[i].pow; ghost_eaten = tbl[i].gho; row = tbl[i].rw;
      tick();
      chk($sformatf("tbl%0d_score", i), {16'd0, score}, {16'd0, tbl[i].exp_score});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
      chk($sformatf("tbl%0d_sat", i), {31'd0, saturated}, {31'd0, tbl[i].exp_sat});
      chk($sformatf("tbl%0d_addr", i), addrs,
          {tbl[i].exp_score[15:12], tbl[i].rw, tbl[i].exp_score[11:8], tbl[i].rw,
           tbl[i].exp_score[7:4], tbl[i].rw, tbl[i].exp_score[3:0], tbl[i].rw});
    end
    clear = 0; pellet_eaten = 0; power_eaten = 0; ghost_eaten = 0;

    // Zero-latency address follow with score 0260, row 5.
    row = 4'd5;
    #1;
    chk("addr_ones_r5", {24'd0, addr_ones}, 32'd5);
    chk("addr_tens_r5", {24'd0, addr_tens}, 32'd101);
    chk("addr_hunds_r5", {24'd0, addr_hunds}, 32'd37);
    chk("addr_thous_r5", {24'd0, addr_thous}, 32'd5);

    // Mid-add clear at E3.
    pellet_eaten = 1; tick(); pellet_eaten = 0;
    tick(); tick();
    clear = 1; tick(); clear = 0;
    chk("midclr_score", {16'd0, score}, 32'd0);
    chk("midclr_busy", {31'd0, busy}, 32'd0);
    repeat (8) tick();
    chk("midclr_after", {16'd0, score}, 32'd0);

    // Carry chain: 0990 + 10 = 1000.
    repeat (4) fire(2);
    repeat (3) fire(1);
    repeat (4) fire(0);
    chk_model("pre_carry", 990, 0);
    fire(0);
    chk_model("carry", 1000, 0);

    // Saturation.
    do_clear();
    repeat (49) fire(2);
    chk_model("preset9800", 9800, 0);
    fire(2);
    chk_model("sat_ghost", 9999, 1);
    fire(0);
    chk_model("sat_pellet", 9999, 1);

    // Four pellet pulses while an add is in flight: cap at 3 -> +40 total.
    do_clear();
    pellet_eaten = 1; tick(); pellet_eaten = 0;
    tick(); tick();
    repeat (4) begin pellet_eaten = 1; tick(); end
    pellet_eaten = 0;
    wait_idle(40);
    chk_model("cap3", 40, 0);

    // Randomized bursts against a decimal model.
    do_clear();
    model = 0; msat = 0;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 14) == 0) begin
        do_clear();
        model = 0; msat = 0;
      end else begin
        bits = $urandom_range(1, 7);
        pellet_eaten = bits[0]; power_eaten = bits[1]; ghost_eaten = bits[2];
        tick();
        pellet_eaten = 0; power_eaten = 0; ghost_eaten = 0;
        wait_idle(30);
        model += (bits[0] ? 10 : 0) + (bits[1] ? 50 : 0) + (bits[2] ? 200 : 0);
        if (msat || model > 9999) begin model = 9999; msat = 1; end
      end
      row = 4'($urandom_range(0, 15));
      #1;
      chk_model($sformatf("rnd%0d", k), model, msat);
    end

    // Reset mid-add.
    do_clear();
    fire(2);
    ghost_eaten = 1; tick(); ghost_eaten = 0;
    tick(); tick();
    Reset_n = 0;
    #2;
    chk("rstmid_score", {16'd0, score}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    Reset_n = 1;
    repeat (8) tick();
    chk("rstmid_after", {15'd0, busy, score}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
